// File: rtl/spm_pkg.sv
// Shared definitions for the SPM memory-dump engine and the risc_spm SRAM.
// Holds the default word/address widths and the dump FSM state encoding.
package spm_pkg;

    localparam int WORD_SIZE = 8;
    localparam int ADDR_SIZE = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } dump_state_t;

endpackage

// File: rtl/spm_addr_ctr.sv
// Dump address counter: loads the start address, holds the end address,
// steps modulo 2**addr_size and flags when it sits on the end address.
module spm_addr_ctr
    import spm_pkg::*;
#(
    parameter int addr_size = ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 inc,
    input  logic [addr_size-1:0] load_start,
    input  logic [addr_size-1:0] load_end,
    output logic [addr_size-1:0] addr,
    output logic                 last
);

    logic [addr_size-1:0] cnt_d, cnt_q;
    logic [addr_size-1:0] end_d, end_q;

    always_comb begin
        cnt_d = cnt_q;
        end_d = end_q;
        if (load) begin
            cnt_d = load_start;
            end_d = load_end;
        end else if (inc) begin
            // natural overflow gives the wrap from the top address to 0
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            end_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            end_q <= end_d;
        end
    end

    assign addr = cnt_q;
    assign last = (cnt_q == end_q);

endmodule

// File: rtl/spm_mem_dump.sv
// Streams an inclusive SRAM address range out over a valid/ready port,
// stalling the CPU off the memory for the duration of the dump.
module spm_mem_dump
    import spm_pkg::*;
#(
    parameter int word_size = WORD_SIZE,
    parameter int addr_size = ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [addr_size-1:0] start_addr,
    input  logic [addr_size-1:0] end_addr,
    output logic [addr_size-1:0] mem_addr,
    output logic                 mem_rd,
    input  logic [word_size-1:0] mem_rdata,
    output logic                 hold_cpu,
    output logic [word_size-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 dout_last,
    output logic                 busy,
    output logic                 done
);

    dump_state_t          state_d, state_q;
    logic [word_size-1:0] dout_d, dout_q;
    logic                 ctr_load, ctr_inc, ctr_last;
    logic [addr_size-1:0] ctr_addr;

    spm_addr_ctr #(.addr_size(addr_size)) u_addr_ctr (
        .clk        (clk),
        .rst        (rst),
        .load       (ctr_load),
        .inc        (ctr_inc),
        .load_start (start_addr),
        .load_end   (end_addr),
        .addr       (ctr_addr),
        .last       (ctr_last)
    );

    always_comb begin
        state_d  = state_q;
        dout_d   = dout_q;
        ctr_load = 1'b0;
        ctr_inc  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // start is only looked at here, so pulses while busy are dropped
                if (start) begin
                    ctr_load = 1'b1;
                    state_d  = ST_READ;
                end
            end
            ST_READ: state_d = ST_WAIT;
            ST_WAIT: begin
                dout_d  = mem_rdata;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (dout_ready) begin
                    if (ctr_last) begin
                        state_d = ST_DONE;
                    end else begin
                        ctr_inc = 1'b1;
                        state_d = ST_READ;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
        end
    end

    assign mem_addr   = ctr_addr;
    assign mem_rd     = (state_q == ST_READ);
    assign busy       = (state_q != ST_IDLE);
    assign hold_cpu   = busy;
    assign dout       = dout_q;
    assign dout_valid = (state_q == ST_SEND);
    assign dout_last  = dout_valid && ctr_last;
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_spm_mem_dump.sv
// Directed bench for spm_mem_dump: SRAM model, word/address scoreboards,
// handshake stability and done-timing monitor.
module tb_spm_mem_dump;

    localparam int DW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] end_addr = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [DW-1:0] mem_rdata = '0;
    logic          hold_cpu;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready = 1'b1;
    logic          dout_last;
    logic          busy;
    logic          done;

    spm_mem_dump #(.word_size(DW), .addr_size(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .hold_cpu   (hold_cpu),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [2**AW];
    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    int tests = 0;
    int fails = 0;
    int dones = 0;
    logic tog = 1'b0;

    logic [DW:0]   exp_q [$];   // {last, word}
    logic [AW-1:0] addr_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (tog) dout_ready = ~dout_ready;
    end

    // monitor: sampled on the falling edge, inputs change 1 time unit after rising
    logic          hold = 1'b0;
    logic [DW:0]   prev = '0;
    logic          pend_done = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            hold = 1'b0;
            pend_done = 1'b0;
        end else begin
            if (pend_done) begin
                chk("done_after_last", {31'd0, done}, 32'd1);
                pend_done = 1'b0;
            end
            if (done) dones++;
            if (hold && dout_valid) chk("dout_stable", {23'd0, dout_last, dout}, {23'd0, prev});
            if (mem_rd) begin
                if (addr_q.size() == 0) chk("extra_read", {24'd0, mem_addr}, 32'hFFFF);
                else chk("mem_addr", {24'd0, mem_addr}, {24'd0, addr_q.pop_front()});
            end
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) chk("extra_word", {23'd0, dout_last, dout}, 32'hFFFF);
                else chk("word", {23'd0, dout_last, dout}, {23'd0, exp_q.pop_front()});
                if (dout_last) pend_done = 1'b1;
            end
            hold = dout_valid && !dout_ready;
            prev = {dout_last, dout};
        end
    end

    // mode 0: ready high, 1: ready toggling, 2: ready held low
    task automatic launch(input logic [AW-1:0] sa, input logic [AW-1:0] ea, input int mode);
        logic [AW-1:0] a;
        int lat;
        a = sa;
        forever begin
            addr_q.push_back(a);
            exp_q.push_back({a == ea, mem[a]});
            if (a == ea) break;
            a = a + 1'b1;
        end
        tog = (mode == 1);
        dout_ready = (mode != 2);
        start_addr = sa;
        end_addr = ea;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_addr = '0;
        end_addr = '0;
        lat = 0;
        while (!dout_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("first_valid_latency", lat, 3);
    endtask

    task automatic finish_dump(input int d0);
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("dump_timeout", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("words_left", exp_q.size(), 0);
        chk("reads_left", addr_q.size(), 0);
        chk("done_count", dones, d0 + 1);
        tog = 1'b0;
        @(posedge clk); #1;
        dout_ready = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {mem_addr, mem_rd, hold_cpu, busy, done, dout, dout_valid, dout_last},
            32'd0);
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = DW'($urandom);
        mem[128] = 8'd6; mem[129] = 8'd1; mem[130] = 8'd2; mem[131] = 8'd0;
        mem[254] = 8'hAA; mem[255] = 8'hBB; mem[0] = 8'h00; mem[1] = 8'h01;
        mem[139] = 8'hF0;

        #3;
        chk_zero("reset_outputs");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        launch(8'd128, 8'd131, 0);
        finish_dump(dones);

        launch(8'd128, 8'd131, 1);
        finish_dump(dones);

        launch(8'd254, 8'd1, 0);
        chk("hold_cpu_eq_busy", {30'd0, hold_cpu, busy}, 32'd3);
        finish_dump(dones);

        // single word, with a start pulse landing mid-SEND
        launch(8'd139, 8'd139, 2);
        start_addr = 8'd0;
        end_addr = 8'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dout_ready = 1'b1;
        finish_dump(dones);

        launch(8'd0, 8'd255, 0);
        finish_dump(dones);

        // reset while the second word is on the output
        launch(8'd128, 8'd131, 2);
        @(posedge clk); #1;
        dout_ready = 1'b1;
        @(posedge clk); #1;
        dout_ready = 1'b0;
        for (int n = 0; n < 20 && !dout_valid; n++) @(negedge clk);
        chk("second_word_held", {23'd0, dout_valid, dout}, {23'd0, 1'b1, 8'd1});
        #2;
        rst = 1'b0;
        #1;
        chk_zero("async_reset_mid_dump");
        exp_q.delete();
        addr_q.delete();
        @(posedge clk); #1;
        chk_zero("reset_held");
        @(posedge clk); #1;
        rst = 1'b1;
        launch(8'd130, 8'd130, 0);
        finish_dump(dones);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
